// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the queued fetch-entry type.
package fetch_pkg;

  localparam int unsigned PC_STEP = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned FE_AW = 32;
  localparam int unsigned FE_IW = 32;

  typedef struct packed {
    logic [FE_AW-1:0] pc4;
    logic [FE_IW-1:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO with flush-style clear; head is read combinationally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: every read is qualified by the count.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[wptr_q] <= wr_data;
  end

  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, decoupling queue, branch redirect.
// Optional counters stat_flush/stat_full under FETCH_QUEUE_STATS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned    DEPTH    = 4,
  parameter int unsigned    AW       = 32,
  parameter int unsigned    IW       = 32,
  parameter logic [AW-1:0]  RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          imem_ready,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          id_stall,
  output logic          if_valid,
  output logic [IW-1:0] if_ins,
  output logic [AW-1:0] if_pc4
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]   stat_flush,
  output logic [15:0]   stat_full
`endif
);

  localparam int unsigned EW = AW + IW;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc4;
  logic          full, empty;
  logic          enq, deq;
  logic [EW-1:0] head;

  assign pc4 = pc_q + AW'(PC_STEP);
  assign deq = if_valid && !id_stall;
  assign enq = imem_ready && (!full || deq);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (br_taken),
    .wr_en   (enq),
    .rd_en   (deq),
    .wr_data ({pc4, imem_data}),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  always_comb begin
    pc_d = pc_q;
    if (br_taken)  pc_d = br_target;
    else if (enq)  pc_d = pc4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign imem_addr = pc_q;

  always_comb begin
    if_valid = !empty;
    if_ins   = '0;
    if_pc4   = '0;
    if (!empty) begin
      if_ins = head[IW-1:0];
      if_pc4 = head[EW-1:IW];
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] flush_q, flush_d;
  logic [15:0] fullc_q, fullc_d;

  always_comb begin
    flush_d = flush_q;
    fullc_d = fullc_q;
    if (br_taken && flush_q != 16'hFFFF)
      flush_d = flush_q + 16'd1;
    if (full && id_stall && fullc_q != 16'hFFFF)
      fullc_d = fullc_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= '0;
      fullc_q <= '0;
    end else begin
      flush_q <= flush_d;
      fullc_q <= fullc_d;
    end
  end

  assign stat_flush = flush_q;
  assign stat_full  = fullc_q;
`endif

endmodule
